// File: rtl/mem_map_pkg.sv
// Shared address map and state encoding for the memory-stage bridge.
package mem_map_pkg;

    localparam logic [31:0] DEF_IO_BASE = 32'hFFFF_0000;

    // Byte offsets of the MMIO registers relative to the IO base address.
    localparam logic [3:0] IO_LED = 4'h0;
    localparam logic [3:0] IO_SW  = 4'h4;
    localparam logic [3:0] IO_CYC = 4'h8;

    typedef enum logic {IDLE, RD_WAIT} bridge_state_t;

endpackage

// File: rtl/mmio_regs.sv
// LED register, free-running cycle counter and the MMIO read mux.
module mmio_regs
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_led_we,
    input  logic [7:0]  i_led_d,
    input  logic [3:0]  i_offset,
    input  logic [7:0]  i_switches,
    output logic [7:0]  o_leds,
    output logic [31:0] o_rd_data
);

    logic [7:0]  r_leds;
    logic [31:0] r_cyc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds <= '0;
            r_cyc  <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (i_led_we) begin
                r_leds <= i_led_d;
            end
        end
    end

    // NOTE: default assigned first so no path through always_comb can infer a latch.
    always_comb begin
        o_rd_data = '0;
        case (i_offset)
            IO_LED:  o_rd_data = {24'd0, r_leds};
            IO_SW:   o_rd_data = {24'd0, i_switches};
            IO_CYC:  o_rd_data = r_cyc;
            default: o_rd_data = '0;
        endcase
    end

    assign o_leds = r_leds;

endmodule

// File: rtl/mem_bridge.sv
// M-stage bridge: address decode, one-cycle RAM read stall, RAM write port,
// MMIO hosting and a sticky access-error flag.
module mem_bridge
    import mem_map_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] IO_BASE = DEF_IO_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [31:0]       DataAdrM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_data,
    input  logic [31:0]       ram_q,
    input  logic [7:0]        switches,
    output logic [7:0]        leds,
    output logic              err
);

    localparam logic [32:0] RAM_BYTES = 33'd4 << ADDR_W;

    bridge_state_t r_state, w_next_state;
    logic          r_err;
    logic          w_ram_hit, w_io_hit, w_aligned, w_bad;
    logic          w_rd_only, w_led_we;
    logic [31:0]   w_io_rd_data;

    assign w_ram_hit = {1'b0, DataAdrM} < RAM_BYTES;
    assign w_io_hit  = DataAdrM[31:4] == IO_BASE[31:4];
    assign w_aligned = DataAdrM[1:0] == 2'b00;
    assign w_rd_only = MemReadM & !MemWriteM;

    // A read and write together is an error, but the write still goes through.
    assign w_bad = ((MemReadM | MemWriteM) & (!w_aligned | !(w_ram_hit | w_io_hit)))
                 | (MemReadM & MemWriteM);

    assign w_led_we = MemWriteM & w_io_hit & w_aligned & (DataAdrM[3:0] == IO_LED);

    mmio_regs u_mmio (
        .clk        (clk),
        .reset      (reset),
        .i_led_we   (w_led_we),
        .i_led_d    (WriteDataM[7:0]),
        .i_offset   (DataAdrM[3:0]),
        .i_switches (switches),
        .o_leds     (leds),
        .o_rd_data  (w_io_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // RD_WAIT always falls back to IDLE; the still-present load is not re-issued.
    always_comb begin
        w_next_state = IDLE;
        if (r_state == IDLE && w_rd_only && w_ram_hit && w_aligned) begin
            w_next_state = RD_WAIT;
        end
    end

    always_comb begin
        StallM    = (r_state == IDLE) & w_rd_only & w_ram_hit & w_aligned;
        ram_wren  = (r_state == IDLE) & MemWriteM & w_ram_hit & w_aligned;
        ReadDataM = '0;
        if (r_state == RD_WAIT) begin
            ReadDataM = ram_q;
        end else if (w_rd_only && w_io_hit && w_aligned) begin
            ReadDataM = w_io_rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign ram_addr = DataAdrM[ADDR_W+1:2];
    assign ram_data = WriteDataM;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with a behavioural one-cycle-latency RAM.
module tb_mem_bridge;

    localparam logic [31:0] IOB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM, MemReadM;
    logic [31:0] DataAdrM, WriteDataM, ReadDataM;
    logic        StallM;
    logic [9:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_data;
    logic [31:0] ram_q;
    logic [7:0]  switches, leds;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] c0, c1;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read; words 0/1 preload to 1/2.
    always @(posedge clk) begin
        if (reset) begin
            mem[0] <= 32'd1;
            mem[1] <= 32'd2;
        end else begin
            if (ram_wren) mem[ram_addr] <= ram_data;
            ram_q <= mem[ram_addr];
        end
    end

    mem_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .DataAdrM   (DataAdrM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .ram_addr   (ram_addr),
        .ram_wren   (ram_wren),
        .ram_data   (ram_data),
        .ram_q      (ram_q),
        .switches   (switches),
        .leds       (leds),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one M-stage request just after the falling edge, then settle.
    task automatic step(input logic rd, input logic wr, input logic [31:0] adr, input logic [31:0] wd);
        @(negedge clk);
        MemReadM   = rd;
        MemWriteM  = wr;
        DataAdrM   = adr;
        WriteDataM = wd;
        #2;
    endtask

    initial begin
        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0;
        DataAdrM = '0; WriteDataM = '0; switches = 8'h3C; ram_q = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_stall", StallM, 0);
        check("rst_leds", leds, 0);
        check("rst_err", err, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_rdata", ReadDataM, 0);

        // RAM store then load
        step(0, 1, 32'h10, 32'hDEAD_BEEF);
        check("st_wren", ram_wren, 1);
        check("st_addr", ram_addr, 4);
        check("st_stall", StallM, 0);
        step(1, 0, 32'h10, 0);
        check("ld_stall1", StallM, 1);
        check("ld_idle_data", ReadDataM, 0);
        step(1, 0, 32'h10, 0);
        check("ld_stall0", StallM, 0);
        check("ld_data", ReadDataM, 32'hDEAD_BEEF);

        // Back-to-back loads
        step(1, 0, 32'h0, 0);
        check("b2b_s0", StallM, 1);
        step(1, 0, 32'h0, 0);
        check("b2b_s1", StallM, 0);
        check("b2b_d0", ReadDataM, 1);
        step(1, 0, 32'h4, 0);
        check("b2b_s2", StallM, 1);
        step(1, 0, 32'h4, 0);
        check("b2b_s3", StallM, 0);
        check("b2b_d1", ReadDataM, 2);
        step(0, 0, 0, 0);
        check("no_err_yet", err, 0);

        // MMIO
        step(0, 1, IOB, 32'h1A5);
        check("led_before", leds, 0);
        step(0, 0, 0, 0);
        check("led_after", leds, 8'hA5);
        step(1, 0, IOB, 0);
        check("led_read", ReadDataM, 32'hA5);
        step(1, 0, IOB + 4, 0);
        check("sw_read", ReadDataM, 32'h3C);
        check("sw_stall", StallM, 0);
        step(1, 0, IOB + 8, 0);
        c0 = ReadDataM;
        step(1, 0, IOB + 8, 0);
        c1 = ReadDataM;
        check("cyc_incr", c1, c0 + 32'd1);
        force dut.u_mmio.r_cyc = 32'hFFFF_FFFF;
        #1;
        check("cyc_max", ReadDataM, 32'hFFFF_FFFF);
        release dut.u_mmio.r_cyc;
        step(1, 0, IOB + 8, 0);
        check("cyc_wrap", ReadDataM, 0);
        step(1, 0, IOB + 12, 0);
        check("io_c_read", ReadDataM, 0);
        check("io_err", err, 0);

        // Errors
        step(0, 1, 32'h13, 32'h1234_5678);
        check("mis_wren", ram_wren, 0);
        step(0, 0, 0, 0);
        check("mis_err", err, 1);
        step(1, 0, 32'h8000_0000, 0);
        check("unmap_data", ReadDataM, 0);
        check("unmap_stall", StallM, 0);
        step(0, 0, 0, 0);
        check("err_sticky", err, 1);
        step(1, 1, 32'h20, 32'h55);
        check("rw_wren", ram_wren, 1);
        check("rw_data", ReadDataM, 0);
        check("rw_stall", StallM, 0);
        step(1, 0, 32'h20, 0);
        check("rw_ld_stall", StallM, 1);
        step(1, 0, 32'h20, 0);
        check("rw_written", ReadDataM, 32'h55);

        // Reset while in RD_WAIT
        step(1, 0, 32'h10, 0);
        check("rl_stall", StallM, 1);
        step(1, 0, 32'h10, 0);
        check("rl_wait_data", ReadDataM, 32'hDEAD_BEEF);
        #1;
        reset = 1'b1;
        MemReadM = 1'b0;
        #1;
        check("rl_stall0", StallM, 0);
        check("rl_idle", ReadDataM, 0);
        check("rl_leds", leds, 0);
        check("rl_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, IOB, 0);
        check("post_rst_led", ReadDataM, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
